// File: rtl/qam_symbol_sampler.sv
// qam_symbol_sampler: picks one matched-filter sample per symbol, slices it to a
// Gray-coded 16-QAM symbol and queues the result in a small FIFO.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            sampling active; low holds the sample counter at 0
//   baud_rate         00=2400, 01=4800, 10=9600, 11=19200 Bd
//   sample_phase      sampling instant within the symbol (masked to SPS-1)
//   din_valid         strobe marking a new filtered sample on din_i/din_q
//   din_i, din_q      signed I/Q samples
//   sym_valid         FIFO non-empty
//   sym_data          {gray_i, gray_q} at the FIFO head
//   sym_ready         consumer pops the head when sym_valid is high
//   fifo_level        FIFO occupancy
//   overflow          sticky: a symbol was dropped on a full FIFO
//   ovf_clr           synchronous clear of overflow
module qam_symbol_sampler #(
  parameter int unsigned             DW         = 68,
  parameter int unsigned             SPS_MIN    = 8,
  parameter logic signed [DW-1:0]    THRESH     = 68'sd1 <<< 60,
  parameter int unsigned             FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           baud_rate,
  input  logic [5:0]           sample_phase,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  output logic                 sym_valid,
  output logic [3:0]           sym_data,
  input  logic                 sym_ready,
  output logic [2:0]           fifo_level,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int unsigned CW = 6;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [1:0]           baud_q;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        sps_mask;
  logic [CW-1:0]        phase_eff;
  logic                 baud_chg;
  logic                 capture;

  logic                 cap_valid;
  logic signed [DW-1:0] cap_i;
  logic signed [DW-1:0] cap_q;
  logic [3:0]           sym_in;

  logic [3:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [2:0]           count;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 ovf_set;

  // Samples per symbol minus one, used as wrap point and phase mask.
  always_comb begin
    sps_mask = CW'(SPS_MIN - 1);
    case (baud_rate)
      2'b00:   sps_mask = CW'(SPS_MIN * 8 - 1);
      2'b01:   sps_mask = CW'(SPS_MIN * 4 - 1);
      2'b10:   sps_mask = CW'(SPS_MIN * 2 - 1);
      default: sps_mask = CW'(SPS_MIN - 1);
    endcase
  end

  assign phase_eff = sample_phase & sps_mask;
  // A baud change restarts the symbol count; that cycle never captures.
  assign baud_chg  = (baud_rate != baud_q);
  assign capture   = din_valid & enable & ~baud_chg & (cnt == phase_eff);

  // Sample counter and baud history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      baud_q <= '0;
    end else begin
      baud_q <= baud_rate;
      if (!enable || baud_chg) begin
        cnt <= '0;
      end else if (din_valid) begin
        cnt <= (cnt == sps_mask) ? '0 : cnt + CW'(1);
      end
    end
  end

  // Slice stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_i     <= '0;
      cap_q     <= '0;
    end else begin
      cap_valid <= capture;
      if (capture) begin
        cap_i <= din_i;
        cap_q <= din_q;
      end
    end
  end

  // Four-level slicer with Gray mapping 00,01,11,10 from most negative up.
  function automatic logic [1:0] gray_slice(input logic signed [DW-1:0] x);
    if (x < -THRESH)     gray_slice = 2'b00;
    else if (x < 0)      gray_slice = 2'b01;
    else if (x < THRESH) gray_slice = 2'b11;
    else                 gray_slice = 2'b10;
  endfunction

  assign sym_in = {gray_slice(cap_i), gray_slice(cap_q)};

  // A pop on a full FIFO frees the slot for a coincident push.
  assign full    = (count == 3'(FIFO_DEPTH));
  assign pop     = (count != 3'd0) & sym_ready;
  assign push_ok = cap_valid & (~full | pop);
  assign ovf_set = cap_valid & full & ~pop;

  // Symbol FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= sym_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign fifo_level = count;
  assign sym_valid  = (count != 3'd0);
  assign sym_data   = mem[rd_ptr];

endmodule
